// File: rtl/code_display_pkg.sv
// -----------------------------------------------------------------------------
// code_display_pkg
//   Shared types and constants for the six-digit code display.
//   - state_t     : display mode (entry progress, OK result, ERR result)
//   - NUM_DIGITS  : number of multiplexed digit positions
//   - SEG_*       : active-low glyphs, bit order {dp,a,b,c,d,e,f,g}
//   - HEX_GLYPH   : 16-entry active-low hex glyph table, indexed by nibble
//   - digit_nibble: extracts the nibble for a display position
// -----------------------------------------------------------------------------
package code_display_pkg;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    SHOW_OK  = 2'd1,
    SHOW_ERR = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFE;  // g only
  localparam logic [7:0] SEG_UNDER = 8'hF7;  // d only
  localparam logic [7:0] SEG_E     = 8'hB0;  // a,d,e,f,g
  localparam logic [7:0] SEG_R     = 8'hFA;  // e,g (lowercase r)

  // Entry [n] is the glyph for nibble n; listed from F down to 0.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'hB8, 8'hB0, 8'hC2, 8'hB1,   // F E d C
    8'hE0, 8'h88, 8'h84, 8'h80,   // b A 9 8
    8'h8F, 8'hA0, 8'hA4, 8'hCC,   // 7 6 5 4
    8'h86, 8'h92, 8'hCF, 8'h81    // 3 2 1 0
  };

  // Position 0 is the leftmost digit and lives in the top nibble.
  function automatic logic [3:0] digit_nibble(input logic [23:0] code,
                                              input logic [2:0]  pos);
    return code[(NUM_DIGITS - 1 - int'(pos)) * 4 +: 4];
  endfunction

endpackage

// File: rtl/code_display_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Combinational 4-bit to active-low 7-segment hex lookup (dp always off).
//   Ports:
//     nibble : in  4  hex value
//     seg    : out 8  active-low {dp,a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
module seg7_decode
  import code_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/code_display.sv
// -----------------------------------------------------------------------------
// code_display
//   Six-digit multiplexed common-anode 7-segment driver. Shows the code as it
//   is entered, then a blinking OK (full code) or ERR ("Err---") indication.
//   Each digit slot starts with one all-off select cycle so the segment lines
//   can settle before the next anode turns on.
//
//   Build option: define CODE_MASK_EN to show entered digits as '_' while in
//   entry mode; the full code is still revealed on success.
//
//   Parameters:
//     SCAN_DIV  : clk cycles per digit slot
//     BLINK_DIV : scan ticks per blink half-period
//   Ports:
//     clk         : in  1   divided system clock
//     rst         : in  1   synchronous active-high reset
//     code        : in  24  entered code, code[23:20] is digit 0 (leftmost)
//     digit_cnt   : in  3   digits entered so far (7 treated as 6)
//     code_finish : in  1   entry complete (level)
//     success     : in  1   compare result, valid while code_finish=1
//     scan_sel    : out 6   active-low digit select, bit i = position i
//     seg         : out 8   active-low segments {dp,a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
module code_display
  import code_display_pkg::*;
#(
  parameter int SCAN_DIV  = 50,
  parameter int BLINK_DIV = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] code,
  input  logic [2:0]  digit_cnt,
  input  logic        code_finish,
  input  logic        success,
  output logic [5:0]  scan_sel,
  output logic [7:0]  seg
);

  localparam int TICK_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [TICK_W-1:0]  tick_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [2:0]         pos;       // position whose glyph is captured next tick
  logic [2:0]         sel_pos;   // position being driven in the current slot
  logic               sel_pend;  // blank cycle done, enable sel_pos next
  logic               phase;     // 1 = lit half of the blink period
  state_t             state;
  state_t             next_state;

  logic       tick;
  logic [2:0] entered_cnt;
  logic       entered;
  logic [7:0] hex_seg;
  logic [7:0] glyph;

  assign tick        = (tick_cnt == TICK_W'(SCAN_DIV - 1));
  assign entered_cnt = (digit_cnt > 3'd6) ? 3'd6 : digit_cnt;
  assign entered     = (pos < entered_cnt);

  seg7_decode u_decode (
    .nibble (digit_nibble(code, pos)),
    .seg    (hex_seg)
  );

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    glyph = SEG_BLANK;
    case (state)
      ENTRY: begin
        if (entered) begin
`ifdef CODE_MASK_EN
          glyph = SEG_UNDER;
`else
          glyph = hex_seg;
`endif
        end
      end
      SHOW_OK: begin
        if (phase) glyph = hex_seg;
      end
      SHOW_ERR: begin
        if (phase) begin
          if (pos == 3'd0)     glyph = SEG_E;
          else if (pos < 3'd3) glyph = SEG_R;
          else                 glyph = SEG_DASH;
        end
      end
      default: glyph = SEG_BLANK;
    endcase
  end

  // The result state is latched: success is only looked at when leaving ENTRY.
  always_comb begin
    next_state = state;
    case (state)
      ENTRY:             if (code_finish) next_state = success ? SHOW_OK : SHOW_ERR;
      SHOW_OK, SHOW_ERR: if (!code_finish) next_state = ENTRY;
      default:           next_state = ENTRY;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; the tick therefore captures the old state's glyph
  // even when the state changes on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      pos       <= '0;
      sel_pos   <= '0;
      sel_pend  <= 1'b0;
      phase     <= 1'b1;
      state     <= ENTRY;
      scan_sel  <= '1;
      seg       <= SEG_BLANK;
    end else begin
      state    <= next_state;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      // Every state starts with a full lit half-period.
      if (next_state != state) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (tick && state != ENTRY) begin
        if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      sel_pend <= tick;
      if (tick) begin
        scan_sel <= '1;
        seg      <= glyph;
        sel_pos  <= pos;
        pos      <= (pos == 3'(NUM_DIGITS - 1)) ? 3'd0 : pos + 3'd1;
      end else if (sel_pend) begin
        scan_sel <= ~(6'b000001 << sel_pos);
      end
    end
  end

endmodule

// File: tb/tb_code_display.sv
// -----------------------------------------------------------------------------
// tb_code_display
//   Scoreboard bench for code_display. The stimulus process pushes the expected
//   (position, glyph) of each upcoming digit slot; the monitor pops one entry
//   each time a new digit select appears and also checks the one-cycle blank.
//   Compile with +define+CODE_MASK_EN to check the masked entry build.
// -----------------------------------------------------------------------------
module tb_code_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  // Hand-derived active-low glyphs {dp,a,b,c,d,e,f,g} for 0..F.
  localparam logic [7:0] HEX_EXP [16] = '{
    8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
    8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] code = '0;
  logic [2:0]  digit_cnt = '0;
  logic        code_finish = 1'b0;
  logic        success = 1'b0;
  logic [5:0]  scan_sel;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  code_display #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .code        (code),
    .digit_cnt   (digit_cnt),
    .code_finish (code_finish),
    .success     (success),
    .scan_sel    (scan_sel),
    .seg         (seg)
  );

  typedef struct packed {
    logic [2:0] pos;
    logic [7:0] seg;
  } slot_t;

  slot_t exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    next_pos = 0;
  int    blink_k  = 0;
  bit    done     = 1'b0;
  bit    rst_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] nib_glyph(input logic [23:0] c, input int p);
    logic [23:0] sh;
    sh = c >> (4 * (5 - p));
    return HEX_EXP[sh[3:0]];
  endfunction

  function automatic logic [7:0] entry_glyph(input logic [23:0] c, input int p, input int cnt);
    int n;
    n = (cnt > 6) ? 6 : cnt;
    if (p >= n) return 8'hFF;
`ifdef CODE_MASK_EN
    return 8'hF7;
`else
    return nib_glyph(c, p);
`endif
  endfunction

  function automatic logic [7:0] err_glyph(input int p);
    if (p == 0) return 8'hB0;
    if (p < 3)  return 8'hFA;
    return 8'hFE;
  endfunction

  task automatic push(input logic [7:0] s);
    slot_t e;
    e.pos = 3'(next_pos);
    e.seg = s;
    exp_q.push_back(e);
    next_pos = (next_pos + 1) % 6;
  endtask

  task automatic push_entry(input int n);
    for (int i = 0; i < n; i++) push(entry_glyph(code, next_pos, int'(digit_cnt)));
  endtask

  task automatic push_ok(input int n);
    for (int i = 0; i < n; i++) begin
      push((((blink_k / BLINK_DIV) % 2) == 0) ? nib_glyph(code, next_pos) : 8'hFF);
      blink_k++;
    end
  endtask

  task automatic push_err(input int n);
    for (int i = 0; i < n; i++) begin
      push((((blink_k / BLINK_DIV) % 2) == 0) ? err_glyph(next_pos) : 8'hFF);
      blink_k++;
    end
  endtask

  // Wait until the monitor has consumed every expected slot; returns just
  // after a negedge so new inputs land well clear of the next tick.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d slots still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Counts clock edges from reset release until the first digit select.
  task automatic first_select_latency();
    int n;
    n = 0;
    while (scan_sel == 6'h3F && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_select_latency", n, 5);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(posedge clk) if (rst) rst_seen = 1'b1;

  int blank_len  = 0;
  bit prev_blank = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      blank_len  = 0;
      prev_blank = 1'b1;
    end else if (scan_sel == 6'h3F) begin
      blank_len++;
      prev_blank = 1'b1;
    end else begin
      if (prev_blank && !done) begin
        int    apos;
        slot_t e;
        apos = 7;
        if ($countones(~scan_sel) == 1)
          for (int i = 0; i < 6; i++) if (!scan_sel[i]) apos = i;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot: pos %0d seg %0h", apos, seg);
        end else begin
          e = exp_q.pop_front();
          check("slot_pos", apos, e.pos);
          check("slot_seg", seg, e.seg);
        end
        if (!rst_seen) check("blank_len", blank_len, 1);
        rst_seen = 1'b0;
      end
      prev_blank = 1'b0;
      blank_len  = 0;
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    code      = 24'h123456;
    digit_cnt = 3'd3;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_scan_sel", scan_sel, 6'h3F);
      check("reset_seg", seg, 8'hFF);
    end
    rst = 1'b0;
    push_entry(12);           // two frames of "123   "
    first_select_latency();
    drain();

    // digit_cnt=7 behaves as 6, exercising letter glyphs.
    code      = 24'h9ABCEF;
    digit_cnt = 3'd7;
    push_entry(6);
    drain();

    // Success: full code blinking, two ticks lit then two blank.
    digit_cnt   = 3'd6;
    code_finish = 1'b1;
    success     = 1'b1;
    blink_k     = 0;
    push_ok(8);
    drain();

    // Back to entry: hex code visible again.
    code_finish = 1'b0;
    push_entry(6);
    drain();

    // Lock cleared down to two digits: dropped digits blank.
    digit_cnt = 3'd2;
    push_entry(6);
    drain();

    // Failure, then success flips mid-blink: must stay on "Err---".
    digit_cnt   = 3'd6;
    code_finish = 1'b1;
    success     = 1'b0;
    blink_k     = 0;
    push_err(3);
    drain();
    success = 1'b1;
    push_err(5);
    while (next_pos != 5) push_err(1);
    drain();

    // One-cycle reset while position 4 is lit.
    rst         = 1'b1;
    code_finish = 1'b0;
    success     = 1'b0;
    next_pos    = 0;
    push_entry(6);
    @(posedge clk);
    #1;
    check("midscan_rst_scan_sel", scan_sel, 6'h3F);
    check("midscan_rst_seg", seg, 8'hFF);
    rst = 1'b0;
    first_select_latency();
    drain();

    done = 1'b1;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
